// File: rtl/jump_physics.sv
// Dino jump controller: synchronises and debounces the jump button, then steps a
// rise/hang/fall height trajectory once per frame tick.
module jump_physics #(
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter int unsigned JUMP_VEL        = 6,
    parameter int unsigned MAX_HEIGHT      = 24,
    parameter int unsigned HANG_FRAMES     = 4,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn1,
    input  logic       frame_tick,
    output logic [5:0] jump_height,
    output logic       airborne,
    output logic       jump_start,
    output logic       landed
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HW = $clog2(HANG_FRAMES + 2);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HANG_LOAD = HW'(HANG_FRAMES);
    localparam logic [3:0]    JV        = 4'(JUMP_VEL);
    localparam logic [6:0]    MAX7      = 7'(MAX_HEIGHT);
    localparam logic          RELEASED_RAW = BTN_ACTIVE_LOW;

    typedef enum logic [1:0] {StIdle, StRise, StHang, StFall} state_e;

    // Input synchroniser and debouncer
    logic          sync1_q, sync2_q;
    logic          btn_level;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic          db_state_q, db_state_d;
    logic          press_q, press_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= RELEASED_RAW;
            sync2_q <= RELEASED_RAW;
        end else begin
            sync1_q <= btn1;
            sync2_q <= sync1_q;
        end
    end

    assign btn_level = sync2_q ^ BTN_ACTIVE_LOW;

    always_comb begin
        db_cnt_d   = '0;
        db_state_d = db_state_q;
        press_d    = 1'b0;
        if (btn_level != db_state_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_state_d = btn_level;
                press_d    = btn_level;  // only the 0->1 toggle is an event
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_q   <= '0;
            db_state_q <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            db_cnt_q   <= db_cnt_d;
            db_state_q <= db_state_d;
            press_q    <= press_d;
        end
    end

    // Trajectory FSM
    state_e        state_q, state_d;
    logic [5:0]    height_q, height_d;
    logic [3:0]    vel_q, vel_d;
    logic [HW-1:0] hang_q, hang_d;
    logic          airborne_q, start_q, start_d, landed_q, landed_d;
    logic [6:0]    h7, vel7, sum7;
    logic [5:0]    diff6;

    assign h7    = {1'b0, height_q};
    assign vel7  = {3'b000, vel_q};
    assign sum7  = h7 + vel7;
    assign diff6 = height_q - {2'b00, vel_q};

    always_comb begin
        state_d  = state_q;
        height_d = height_q;
        vel_d    = vel_q;
        hang_d   = hang_q;
        start_d  = 1'b0;
        landed_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (press_q) begin
                    state_d  = StRise;
                    vel_d    = JV;
                    height_d = '0;
                    start_d  = 1'b1;
                end
            end
            StRise: begin
                if (frame_tick) begin
                    if (sum7 >= MAX7) begin
                        height_d = MAX7[5:0];
                        state_d  = StHang;
                        hang_d   = HANG_LOAD;
                    end else begin
                        height_d = sum7[5:0];
                        vel_d    = vel_q - 4'd1;
                        if (vel_q == 4'd1) begin
                            state_d = StHang;
                            hang_d  = HANG_LOAD;
                        end
                    end
                end
            end
            StHang: begin
                // A zero load also leaves on the first tick
                if (frame_tick) begin
                    if (hang_q <= HW'(1)) begin
                        state_d = StFall;
                        vel_d   = 4'd1;
                        hang_d  = '0;
                    end else begin
                        hang_d = hang_q - HW'(1);
                    end
                end
            end
            StFall: begin
                if (frame_tick) begin
                    if (h7 <= vel7) begin
                        height_d = '0;
                        vel_d    = '0;
                        state_d  = StIdle;
                        landed_d = 1'b1;
                    end else begin
                        height_d = diff6;
                        if (vel_q < JV) begin
                            vel_d = vel_q + 4'd1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            height_q   <= '0;
            vel_q      <= '0;
            hang_q     <= '0;
            airborne_q <= 1'b0;
            start_q    <= 1'b0;
            landed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            height_q   <= height_d;
            vel_q      <= vel_d;
            hang_q     <= hang_d;
            airborne_q <= (state_d != StIdle);
            start_q    <= start_d;
            landed_q   <= landed_d;
        end
    end

    assign jump_height = height_q;
    assign airborne    = airborne_q;
    assign jump_start  = start_q;
    assign landed      = landed_q;

endmodule

// File: tb/tb_jump_physics.sv
// Scoreboard bench for jump_physics: stimulus pushes hand-computed records, per-DUT
// monitors pop and compare whenever a tick, reset release or pulse output occurs.
module tb_jump_physics;

    typedef struct packed {
        logic [5:0] h;
        logic       air;
        logic       js;
        logic       ld;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn1 = 1'b1;
    logic btn16 = 1'b1;
    logic frame_tick = 1'b0;
    logic tick16 = 1'b0;

    logic [5:0] h_main, h_alt;
    logic air_main, js_main, ld_main, air_alt, js_alt, ld_alt;

    int checks = 0;
    int errors = 0;
    rec_t q_main[$];
    rec_t q_alt[$];

    logic [5:0] seq_main [16] = '{6, 11, 15, 18, 20, 21, 21, 21, 21, 21, 20, 18, 15, 11, 6, 0};
    logic [5:0] seq_alt  [14] = '{6, 11, 15, 16, 16, 16, 16, 16, 15, 13, 10, 6, 1, 0};

    always #5 clk = ~clk;

    jump_physics #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn1       (btn1),
        .frame_tick (frame_tick),
        .jump_height(h_main),
        .airborne   (air_main),
        .jump_start (js_main),
        .landed     (ld_main)
    );

    jump_physics #(
        .DEBOUNCE_CYCLES(4),
        .MAX_HEIGHT     (16)
    ) dut_alt (
        .clk        (clk),
        .rst        (rst),
        .btn1       (btn16),
        .frame_tick (tick16),
        .jump_height(h_alt),
        .airborne   (air_alt),
        .jump_start (js_alt),
        .landed     (ld_alt)
    );

    function automatic void compare(input string name, input rec_t act, input rec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got h=%0d air=%0b js=%0b ld=%0b, want h=%0d air=%0b js=%0b ld=%0b",
                     name, act.h, act.air, act.js, act.ld, exp.h, exp.air, exp.js, exp.ld);
        end
    endfunction

    // Monitors
    logic prev_tick_m = 1'b0, prev_rst_m = 1'b0;
    always @(negedge clk) begin
        rec_t e;
        if (prev_tick_m || (prev_rst_m && !rst) || js_main === 1'b1 || ld_main === 1'b1) begin
            if (q_main.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL main_unexpected: got h=%0d js=%0b ld=%0b, want no event",
                         h_main, js_main, ld_main);
            end else begin
                e = q_main.pop_front();
                compare("main", {h_main, air_main, js_main, ld_main}, e);
            end
        end
        prev_tick_m = frame_tick;
        prev_rst_m  = rst;
    end

    logic prev_tick_a = 1'b0, prev_rst_a = 1'b0;
    always @(negedge clk) begin
        rec_t e;
        if (prev_tick_a || (prev_rst_a && !rst) || js_alt === 1'b1 || ld_alt === 1'b1) begin
            if (q_alt.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL alt_unexpected: got h=%0d js=%0b ld=%0b, want no event",
                         h_alt, js_alt, ld_alt);
            end else begin
                e = q_alt.pop_front();
                compare("alt16", {h_alt, air_alt, js_alt, ld_alt}, e);
            end
        end
        prev_tick_a = tick16;
        prev_rst_a  = rst;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_main(input logic [5:0] h, input logic air, input logic ld);
        q_main.push_back({h, air, 1'b0, ld});
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(9);
    endtask

    task automatic tick_alt(input logic [5:0] h, input logic air, input logic ld);
        q_alt.push_back({h, air, 1'b0, ld});
        tick16 = 1'b1;
        step(1);
        tick16 = 1'b0;
        step(9);
    endtask

    task automatic pulse_reset();
        q_main.push_back({6'd0, 1'b0, 1'b0, 1'b0});
        q_alt.push_back({6'd0, 1'b0, 1'b0, 1'b0});
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish before 1 ms");
        $fatal(1, "timeout");
    end

    initial begin
        // Power-on reset
        q_main.push_back({6'd0, 1'b0, 1'b0, 1'b0});
        q_alt.push_back({6'd0, 1'b0, 1'b0, 1'b0});
        step(3);
        rst = 1'b0;
        step(3);

        // Three-clock glitch must not start a jump
        btn1 = 1'b0;
        step(3);
        btn1 = 1'b1;
        step(10);
        tick_main(6'd0, 1'b0, 1'b0);
        tick_main(6'd0, 1'b0, 1'b0);

        // Full jump with the button held past landing
        q_main.push_back({6'd0, 1'b1, 1'b1, 1'b0});
        btn1 = 1'b0;
        step(12);
        for (int i = 0; i < 16; i++) tick_main(seq_main[i], (i != 15), (i == 15));
        tick_main(6'd0, 1'b0, 1'b0);
        tick_main(6'd0, 1'b0, 1'b0);
        btn1 = 1'b1;
        step(12);

        // Re-press starts a second jump; a press during the fall is ignored
        q_main.push_back({6'd0, 1'b1, 1'b1, 1'b0});
        btn1 = 1'b0;
        step(12);
        btn1 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 11) btn1 = 1'b0;
            tick_main(seq_main[i], (i != 15), (i == 15));
        end
        tick_main(6'd0, 1'b0, 1'b0);
        tick_main(6'd0, 1'b0, 1'b0);
        btn1 = 1'b1;
        step(12);

        // Reset at height 18 clears everything without a landed pulse
        q_main.push_back({6'd0, 1'b1, 1'b1, 1'b0});
        btn1 = 1'b0;
        step(12);
        btn1 = 1'b1;
        for (int i = 0; i < 4; i++) tick_main(seq_main[i], 1'b1, 1'b0);
        pulse_reset();
        tick_main(6'd0, 1'b0, 1'b0);

        // Lower ceiling clamps the rise at 16
        q_alt.push_back({6'd0, 1'b1, 1'b1, 1'b0});
        btn16 = 1'b0;
        step(12);
        btn16 = 1'b1;
        for (int i = 0; i < 14; i++) tick_alt(seq_alt[i], (i != 13), (i == 13));
        tick_alt(6'd0, 1'b0, 1'b0);

        step(20);
        checks++;
        if (q_main.size() != 0) begin
            errors++;
            $display("FAIL main_drain: got %0d pending, want 0", q_main.size());
        end
        checks++;
        if (q_alt.size() != 0) begin
            errors++;
            $display("FAIL alt_drain: got %0d pending, want 0", q_alt.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
